// File: rtl/next_pc_predictor_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor.
//   XLEN    : architectural PC width
//   PC_STEP : sequential fetch increment
//   ctr_e   : 2-bit branch direction counter states
package next_pc_predictor_pkg;

  localparam int              XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } ctr_e;

endpackage

// File: rtl/next_pc_predictor_sat_counter2.sv
// 2-bit saturating counter next-state logic (purely combinational).
//   ctr      in  current counter state
//   inc      in  1 = count toward taken, 0 = count toward not taken
//   ctr_next out next counter state, held at ST / SNT when saturated
module sat_counter2
  import next_pc_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic inc,
  output ctr_e ctr_next
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and no latch is inferred.
  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != ST) ctr_next = ctr_e'(ctr + 2'b01);
    end else begin
      if (ctr != SNT) ctr_next = ctr_e'(ctr - 2'b01);
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generator with a direct-mapped BTB and 2-bit counters.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   pc_f, stall_f     current fetch PC and PC-register hold
//   ex_*              branch/jump resolution from EX and the prediction it carried
//   pc_next           next value for the PC register
//   pred_taken_f      prediction for pc_f
//   pred_target_f     predicted target for pc_f (pc_f+4 on a BTB miss)
//   redirect          EX mispredict: flush IF/ID and ID/EX this cycle
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int              ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_f,
  input  logic            stall_f,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_next,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  output logic            redirect
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  // BTB storage as flop arrays
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jmp_q;
  ctr_e               ctr_q [ENTRIES];
  logic [TAGW-1:0]    tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic            pending_q;
  logic [XLEN-1:0] pending_pc_q;

  // Fetch-side lookup
  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic [XLEN-1:0] pc_f_seq;

  assign f_idx    = pc_f[IDX+1:2];
  assign f_tag    = pc_f[XLEN-1:IDX+2];
  assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pc_f_seq = pc_f + PC_STEP;

  assign pred_taken_f  = f_hit && (jmp_q[f_idx] || (ctr_q[f_idx] inside {WT, ST}));
  assign pred_target_f = f_hit ? tgt_q[f_idx] : pc_f_seq;

  // EX-side resolution
  logic            resolve;
  logic            act_taken;
  logic            mispredict;
  logic [XLEN-1:0] fix_pc;
  logic [IDX-1:0]  ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  ctr_e            ctr_upd;

  assign resolve    = ex_valid && (ex_is_branch || ex_is_jump);
  assign act_taken  = ex_taken || ex_is_jump;
  assign mispredict = resolve && ((act_taken != ex_pred_taken) ||
                                  (act_taken && (ex_target != ex_pred_target)));
  assign fix_pc     = act_taken ? ex_target : (ex_pc + PC_STEP);
  assign ex_idx     = ex_pc[IDX+1:2];
  assign ex_tag     = ex_pc[XLEN-1:IDX+2];
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_counter2 u_ctr_upd (
    .ctr      (ctr_q[ex_idx]),
    .inc      (act_taken),
    .ctr_next (ctr_upd)
  );

  assign redirect = mispredict;

  // A correction from EX wins, then a correction parked during a stall,
  // then the BTB prediction.
  always_comb begin
    pc_next = pred_taken_f ? pred_target_f : pc_f_seq;
    if (mispredict)     pc_next = fix_pc;
    else if (pending_q) pc_next = pending_pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, giving the lookup/update same-cycle ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (resolve) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_upd;
      end else if (act_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= ex_is_jump ? ST : WT;
      end
    end
  end

  // NOTE: tag/target/jump arrays are not reset; they are only observed
  // through a set valid bit, so clearing valid_q is enough to flush the BTB.
  always_ff @(posedge clk) begin
    if (resolve && (ex_hit || act_taken)) begin
      tag_q[ex_idx] <= ex_tag;
      jmp_q[ex_idx] <= ex_is_jump;
      if (act_taken) tgt_q[ex_idx] <= ex_target;
    end
  end

  // Park a correction that the stalled PC register could not take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_PC;
    end else if (mispredict && stall_f) begin
      pending_q    <= 1'b1;
      pending_pc_q <= fix_pc;
    end else if (!stall_f) begin
      pending_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench for next_pc_predictor: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the predictor.
module tb_next_pc_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_f = '0;
  logic        stall_f = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jump = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic [31:0] pc_next;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        redirect;

  int n_checks = 0;
  int n_fail   = 0;

  next_pc_predictor #(.ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_f           (pc_f),
    .stall_f        (stall_f),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_taken       (ex_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_next        (pc_next),
    .pred_taken_f   (pred_taken_f),
    .pred_target_f  (pred_target_f),
    .redirect       (redirect)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot remembers the full PC of the branch it holds; a lookup hits
  // when the word address matches exactly.
  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          m_jmp   [N];
  bit          m_pending;
  logic [31:0] m_pending_pc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s] && ((m_pc[s] >> 2) == (pc >> 2));
  endfunction

  function automatic bit m_act();
    return ex_taken || ex_is_jump;
  endfunction

  function automatic bit m_resolve();
    return ex_valid && (ex_is_branch || ex_is_jump);
  endfunction

  function automatic bit m_mis();
    return m_resolve() && ((m_act() != ex_pred_taken) ||
                           (m_act() && ex_target != ex_pred_target));
  endfunction

  function automatic logic [31:0] m_fix();
    return m_act() ? ex_target : ex_pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
      m_pending    <= 1'b0;
      m_pending_pc <= 32'h0;
    end else begin
      if (m_resolve()) begin
        if (m_hit(ex_pc)) begin
          m_ctr[slot(ex_pc)] <= m_act() ? ((m_ctr[slot(ex_pc)] == 3) ? 3 : m_ctr[slot(ex_pc)] + 1)
                                        : ((m_ctr[slot(ex_pc)] == 0) ? 0 : m_ctr[slot(ex_pc)] - 1);
          m_jmp[slot(ex_pc)] <= ex_is_jump;
          if (m_act()) m_tgt[slot(ex_pc)] <= ex_target;
        end else if (m_act()) begin
          m_valid[slot(ex_pc)] <= 1'b1;
          m_pc[slot(ex_pc)]    <= ex_pc;
          m_tgt[slot(ex_pc)]   <= ex_target;
          m_jmp[slot(ex_pc)]   <= ex_is_jump;
          m_ctr[slot(ex_pc)]   <= ex_is_jump ? 3 : 2;
        end
      end
      if (m_mis() && stall_f) begin
        m_pending    <= 1'b1;
        m_pending_pc <= m_fix();
      end else if (!stall_f) begin
        m_pending <= 1'b0;
      end
    end
  end

  // Compare process: outputs are combinational and meaningful every cycle.
  always @(negedge clk) begin
    bit          hit, ptk;
    logic [31:0] ptgt, nxt;
    hit  = m_hit(pc_f);
    ptk  = hit && (m_jmp[slot(pc_f)] || m_ctr[slot(pc_f)] >= 2);
    ptgt = hit ? m_tgt[slot(pc_f)] : pc_f + 32'd4;
    if (m_mis())        nxt = m_fix();
    else if (m_pending) nxt = m_pending_pc;
    else if (ptk)       nxt = ptgt;
    else                nxt = pc_f + 32'd4;
    check("model_pred_taken",  {31'b0, pred_taken_f}, {31'b0, ptk});
    check("model_pred_target", pred_target_f, ptgt);
    check("model_redirect",    {31'b0, redirect}, {31'b0, m_mis()});
    check("model_pc_next",     pc_next, nxt);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] pc, input logic stall, input logic v,
                       input logic br, input logic jp, input logic tk,
                       input logic [31:0] epc, input logic [31:0] etgt,
                       input logic ept, input logic [31:0] eptgt);
    pc_f = pc; stall_f = stall; ex_valid = v; ex_is_branch = br; ex_is_jump = jp;
    ex_taken = tk; ex_pc = epc; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
  endtask

  task automatic idle(input logic [31:0] pc, input logic stall);
    drive(pc, stall, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2);
  endfunction

  initial begin
    // 1: reset and sequential fetch
    idle(32'h0, 1'b0);
    tick();
    #2;
    check("rst_pc_next",    pc_next, 32'h4);
    check("rst_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    check("rst_redirect",   {31'b0, redirect}, 32'h0);
    rst_n = 1'b1;
    tick();
    idle(32'h4, 1'b0);
    #2 check("seq_pc_next", pc_next, 32'h8);
    tick();

    // 2: branch at 0x40 taken to 0x100, predicted not taken
    drive(32'h44, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 32'h44);
    #2;
    check("t2_redirect", {31'b0, redirect}, 32'h1);
    check("t2_pc_next",  pc_next, 32'h100);
    tick();
    idle(32'h40, 1'b0);
    #2;
    check("t2_pred_taken",  {31'b0, pred_taken_f}, 32'h1);
    check("t2_pred_target", pred_target_f, 32'h100);
    tick();

    // 3: two not-taken resolutions walk the counter down
    drive(32'h104, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 1'b1, 32'h100);
    #2 check("t3_fix_pc", pc_next, 32'h44);
    tick();
    drive(32'h48, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 1'b0, 32'h44);
    #2 check("t3_no_redirect", {31'b0, redirect}, 32'h0);
    tick();
    idle(32'h40, 1'b0);
    #2;
    check("t3_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    check("t3_pc_next",    pc_next, 32'h44);
    tick();

    // 4: mispredict while stalled is held for three cycles
    drive(32'h50, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1f0, 32'h200, 1'b0, 32'h1f4);
    #2 check("t4_pc_next_c0", pc_next, 32'h200);
    tick();
    idle(32'h50, 1'b1);
    #2 check("t4_pc_next_c1", pc_next, 32'h200);
    tick();
    #2 check("t4_pc_next_c2", pc_next, 32'h200);
    tick();
    idle(32'h50, 1'b0);
    #2 check("t4_pc_next_release", pc_next, 32'h200);
    tick();
    idle(32'h200, 1'b0);
    #2 check("t4_pending_cleared", pc_next, 32'h204);
    tick();

    // 5: JALR at 0x80 (aliases 0x40's slot), then target changes
    drive(32'h84, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h300, 1'b0, 32'h84);
    #2 check("t5_alloc_redirect", {31'b0, redirect}, 32'h1);
    tick();
    idle(32'h80, 1'b0);
    #2 check("t5_pred_target_300", pred_target_f, 32'h300);
    tick();
    drive(32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h340, 1'b1, 32'h300);
    #2;
    check("t5_redirect", {31'b0, redirect}, 32'h1);
    check("t5_pc_next",  pc_next, 32'h340);
    tick();
    idle(32'h80, 1'b0);
    #2 check("t5_tgt_updated", pred_target_f, 32'h340);
    tick();

    // 6: 0x40 now misses; reset in the middle of a pending redirect
    idle(32'h40, 1'b0);
    #2;
    check("t6_alias_miss",   {31'b0, pred_taken_f}, 32'h0);
    check("t6_alias_target", pred_target_f, 32'h44);
    tick();
    drive(32'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h90, 32'h500, 1'b1, 32'h500);
    #2 check("t6_fix_pc", pc_next, 32'h94);
    tick();
    idle(32'h80, 1'b1);
    #2 check("t6_pending", pc_next, 32'h94);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pc_next", pc_next, 32'h84);
    check("t6_rst_pred",    {31'b0, pred_taken_f}, 32'h0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    idle(32'h80, 1'b0);
    #2 check("t6_after_rst", pc_next, 32'h84);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int          kind;
      logic [31:0] tgt;
      kind = int'($urandom_range(0, 3));
      tgt  = rand_pc();
      drive(rand_pc(), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
            (kind == 1 || kind == 2), (kind == 3), $urandom_range(0, 1) == 1,
            rand_pc(), tgt, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? tgt : rand_pc());
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
